dcache_mshr: RTL and testbench

//  Miss-status holding registers directly upstream of the data cache.
//  - Accepts load/store misses from the load/store unit and issues BUS_LOAD block requests to memory.
//  - Matches tagged memory responses and replays each fetched block into the dcache fill port.
//  - The store payload travels with the fill so the cache merges it on write.

---
 rtl/dcache_mshr_pkg.sv | 33 +++
 rtl/dcache_mshr_lowest_sel.sv | 14 +
 rtl/dcache_mshr.sv | 134 +++++++++++++
 tb/tb_dcache_mshr.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_mshr_pkg.sv
// Shared types for the dcache miss-status holding registers: bus/memory encodings,
// per-entry state and the block-address helper.
package dcache_mshr_pkg;

    localparam int MSHR_DEPTH_DEF = 4;

    typedef enum logic [1:0] {BUS_NONE, BUS_LOAD, BUS_STORE} BUS_COMMAND;
    typedef enum logic [1:0] {BYTE, HALF, WORD, DOUBLE} MEM_SIZE;
    typedef logic [3:0]  MEM_TAG;
    typedef logic [63:0] MEM_BLOCK;

    typedef enum logic [1:0] {
        MSHR_INVALID,
        MSHR_WAIT_ISSUE,
        MSHR_WAIT_DATA,
        MSHR_WAIT_FILL
    } MSHR_STATE;

    typedef struct packed {
        MSHR_STATE   state;
        logic [31:0] addr;
        MEM_TAG      mem_tag;
        MEM_BLOCK    block;
        logic        is_store;
        MEM_SIZE     st_size;
        logic [31:0] st_data;
    } MSHR_ENTRY;

    function automatic logic [31:0] blk_addr(input logic [31:0] a);
        return {a[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/dcache_mshr_lowest_sel.sv
// One-hot select of the lowest set request bit, plus an any-set flag.
// Purely combinational; no backpressure.
module mshr_lowest_sel #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_onehot,
    output logic         o_vld
);

    assign o_onehot = i_req & (~i_req + {{(N-1){1'b0}}, 1'b1});
    assign o_vld    = |i_req;

endmodule

// File: rtl/dcache_mshr.sv
// MSHR file: allocate on miss, issue BUS_LOAD, match tagged response, replay fill into dcache.
// Issue and fill are combinational from registered state; fill holds until dcache_fill_ready. Optional DCACHE_MSHR_MERGE_EN.
module dcache_mshr
    import dcache_mshr_pkg::*;
#(
    parameter int MSHR_DEPTH = MSHR_DEPTH_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        miss_valid,
    input  logic [31:0] miss_addr,
    input  logic        miss_is_store,
    input  MEM_SIZE     miss_st_size,
    input  logic [31:0] miss_st_data,
    output logic        miss_ready,
    output BUS_COMMAND  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    input  MEM_TAG      mem2proc_transaction_tag,
    input  MEM_TAG      mem2proc_data_tag,
    input  MEM_BLOCK    mem2proc_data,
    input  logic        dcache_fill_ready,
    output logic        mshr2Dcache_wr,
    output logic [31:0] mshr2Dcache_addr,
    output MEM_BLOCK    mshr2Dcache_mem_block,
    output logic        mshr2Dcache_is_store,
    output MEM_SIZE     mshr2Dcache_st_size,
    output logic [31:0] mshr2Dcache_st_data
`ifdef DCACHE_MSHR_MERGE_EN
    ,
    output logic        miss_merged
`endif
);

    MSHR_ENTRY r_ent [MSHR_DEPTH];

    logic [MSHR_DEPTH-1:0] w_inv, w_wiss, w_wfill;
    logic [MSHR_DEPTH-1:0] w_alloc_oh, w_iss_oh, w_fill_oh;
    logic                  w_alloc_vld, w_iss_vld, w_fill_vld;
    logic                  w_merge_hit, w_alloc_go;

    always_comb begin
        w_inv   = '0;
        w_wiss  = '0;
        w_wfill = '0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            w_inv[i]   = (r_ent[i].state == MSHR_INVALID);
            w_wiss[i]  = (r_ent[i].state == MSHR_WAIT_ISSUE);
            w_wfill[i] = (r_ent[i].state == MSHR_WAIT_FILL);
        end
    end

    mshr_lowest_sel #(.N(MSHR_DEPTH)) u_alloc_sel (.i_req(w_inv),   .o_onehot(w_alloc_oh), .o_vld(w_alloc_vld));
    mshr_lowest_sel #(.N(MSHR_DEPTH)) u_issue_sel (.i_req(w_wiss),  .o_onehot(w_iss_oh),   .o_vld(w_iss_vld));
    mshr_lowest_sel #(.N(MSHR_DEPTH)) u_fill_sel  (.i_req(w_wfill), .o_onehot(w_fill_oh),  .o_vld(w_fill_vld));

    assign miss_ready = w_alloc_vld;

`ifdef DCACHE_MSHR_MERGE_EN
    // A load can piggyback on an in-flight non-store fetch of the same block.
    always_comb begin
        w_merge_hit = 1'b0;
        if (!miss_is_store) begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                if ((r_ent[i].state == MSHR_WAIT_ISSUE || r_ent[i].state == MSHR_WAIT_DATA) &&
                    !r_ent[i].is_store && blk_addr(r_ent[i].addr) == blk_addr(miss_addr))
                    w_merge_hit = 1'b1;
            end
        end
    end
    assign miss_merged = miss_valid && w_merge_hit;
`else
    assign w_merge_hit = 1'b0;
`endif

    assign w_alloc_go = miss_valid && w_alloc_vld && !w_merge_hit;

    always_comb begin
        proc2mem_command      = BUS_NONE;
        proc2mem_addr         = '0;
        mshr2Dcache_wr        = w_fill_vld;
        mshr2Dcache_addr      = '0;
        mshr2Dcache_mem_block = '0;
        mshr2Dcache_is_store  = 1'b0;
        mshr2Dcache_st_size   = BYTE;
        mshr2Dcache_st_data   = '0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (w_iss_oh[i]) begin
                proc2mem_command = BUS_LOAD;
                proc2mem_addr    = blk_addr(r_ent[i].addr);
            end
            if (w_fill_oh[i]) begin
                mshr2Dcache_addr      = r_ent[i].addr;
                mshr2Dcache_mem_block = r_ent[i].block;
                mshr2Dcache_is_store  = r_ent[i].is_store;
                mshr2Dcache_st_size   = r_ent[i].st_size;
                mshr2Dcache_st_data   = r_ent[i].st_data;
            end
        end
    end

    // Each transition is gated by the entry's own state, so alloc/issue/response/fill never collide.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MSHR_DEPTH; i++)
                r_ent[i] <= '0;
        end else begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                case (r_ent[i].state)
                    MSHR_INVALID: if (w_alloc_go && w_alloc_oh[i]) begin
                        r_ent[i].state    <= MSHR_WAIT_ISSUE;
                        r_ent[i].addr     <= miss_addr;
                        r_ent[i].mem_tag  <= '0;
                        r_ent[i].block    <= '0;
                        r_ent[i].is_store <= miss_is_store;
                        r_ent[i].st_size  <= miss_st_size;
                        r_ent[i].st_data  <= miss_st_data;
                    end
                    MSHR_WAIT_ISSUE: if (w_iss_oh[i] && mem2proc_transaction_tag != '0) begin
                        r_ent[i].state   <= MSHR_WAIT_DATA;
                        r_ent[i].mem_tag <= mem2proc_transaction_tag;
                    end
                    MSHR_WAIT_DATA: if (mem2proc_data_tag != '0 && mem2proc_data_tag == r_ent[i].mem_tag) begin
                        r_ent[i].state <= MSHR_WAIT_FILL;
                        r_ent[i].block <= mem2proc_data;
                    end
                    MSHR_WAIT_FILL: if (w_fill_oh[i] && dcache_fill_ready)
                        r_ent[i].state <= MSHR_INVALID;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dcache_mshr.sv
module tb_dcache_mshr;
    import dcache_mshr_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        miss_is_store;
    MEM_SIZE     miss_st_size;
    logic [31:0] miss_st_data;
    logic        miss_ready;
    BUS_COMMAND  proc2mem_command;
    logic [31:0] proc2mem_addr;
    MEM_TAG      mem2proc_transaction_tag;
    MEM_TAG      mem2proc_data_tag;
    MEM_BLOCK    mem2proc_data;
    logic        dcache_fill_ready;
    logic        mshr2Dcache_wr;
    logic [31:0] mshr2Dcache_addr;
    MEM_BLOCK    mshr2Dcache_mem_block;
    logic        mshr2Dcache_is_store;
    MEM_SIZE     mshr2Dcache_st_size;
    logic [31:0] mshr2Dcache_st_data;
`ifdef DCACHE_MSHR_MERGE_EN
    logic        miss_merged;
`endif

    dcache_mshr dut (
        .clock(clock), .reset(reset),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_is_store(miss_is_store),
        .miss_st_size(miss_st_size), .miss_st_data(miss_st_data), .miss_ready(miss_ready),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .mem2proc_transaction_tag(mem2proc_transaction_tag),
        .mem2proc_data_tag(mem2proc_data_tag), .mem2proc_data(mem2proc_data),
        .dcache_fill_ready(dcache_fill_ready), .mshr2Dcache_wr(mshr2Dcache_wr),
        .mshr2Dcache_addr(mshr2Dcache_addr), .mshr2Dcache_mem_block(mshr2Dcache_mem_block),
        .mshr2Dcache_is_store(mshr2Dcache_is_store), .mshr2Dcache_st_size(mshr2Dcache_st_size),
        .mshr2Dcache_st_data(mshr2Dcache_st_data)
`ifdef DCACHE_MSHR_MERGE_EN
        , .miss_merged(miss_merged)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] addr;
        MEM_BLOCK    blk;
        logic        is_st;
        MEM_SIZE     sz;
        logic [31:0] sd;
    } fill_t;

    logic [31:0] q_bus [$];
    fill_t       q_fill [$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_miss(input logic [31:0] a, input logic st, input MEM_SIZE sz, input logic [31:0] sd);
        miss_valid    = 1'b1;
        miss_addr     = a;
        miss_is_store = st;
        miss_st_size  = sz;
        miss_st_data  = sd;
    endtask

    task automatic clr_miss();
        miss_valid    = 1'b0;
        miss_addr     = '0;
        miss_is_store = 1'b0;
        miss_st_size  = BYTE;
        miss_st_data  = '0;
    endtask

    task automatic respond(input MEM_TAG t, input logic [31:0] fa, input MEM_BLOCK d,
                           input logic st, input MEM_SIZE sz, input logic [31:0] sd);
        mem2proc_data_tag = t;
        mem2proc_data     = d;
        q_fill.push_back('{addr: fa, blk: d, is_st: st, sz: sz, sd: sd});
    endtask

    // Monitor: consumes expected bus requests and fills as the DUT hands them over.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && proc2mem_command == BUS_LOAD && mem2proc_transaction_tag != '0) begin
                n_vec++;
                if (q_bus.size() == 0) begin
                    n_err++;
                    $display("FAIL bus_unexpected: got addr %h expected no request", proc2mem_addr);
                end else begin
                    logic [31:0] ea;
                    ea = q_bus.pop_front();
                    if (proc2mem_addr !== ea) begin
                        n_err++;
                        $display("FAIL bus_addr: got %h expected %h", proc2mem_addr, ea);
                    end
                end
            end
            if (!reset && mshr2Dcache_wr && dcache_fill_ready) begin
                fill_t act;
                act = '{addr: mshr2Dcache_addr, blk: mshr2Dcache_mem_block, is_st: mshr2Dcache_is_store,
                        sz: mshr2Dcache_st_size, sd: mshr2Dcache_st_data};
                n_vec++;
                if (q_fill.size() == 0) begin
                    n_err++;
                    $display("FAIL fill_unexpected: got %h expected no fill", act);
                end else begin
                    fill_t ef;
                    ef = q_fill.pop_front();
                    if (act !== ef) begin
                        n_err++;
                        $display("FAIL fill: got %h expected %h", act, ef);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        clr_miss();
        mem2proc_transaction_tag = '0;
        mem2proc_data_tag = '0;
        mem2proc_data = '0;
        dcache_fill_ready = 1'b0;
        tick(); tick();
        chk("rst_miss_ready", 64'(miss_ready), 64'd1);
        chk("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("rst_bus_addr", 64'(proc2mem_addr), 64'd0);
        chk("rst_wr", 64'(mshr2Dcache_wr), 64'd0);
        chk("rst_fill_addr", 64'(mshr2Dcache_addr), 64'd0);
        chk("rst_fill_blk", mshr2Dcache_mem_block, 64'd0);
        reset = 1'b0;

        // single load miss
        set_miss(32'h1004, 1'b0, BYTE, 32'h0);
        chk("t1_no_issue_on_alloc", 64'(proc2mem_command), 64'(BUS_NONE));
        q_bus.push_back(32'h1000);
        tick(); clr_miss();
        mem2proc_transaction_tag = 4'd3;
        chk("t1_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
        chk("t1_addr", 64'(proc2mem_addr), 64'h1000);
        tick();
        mem2proc_transaction_tag = '0;
        respond(4'd3, 32'h1004, 64'hAABBCCDD_11223344, 1'b0, BYTE, 32'h0);
        chk("t1_no_early_fill", 64'(mshr2Dcache_wr), 64'd0);
        tick();
        mem2proc_data_tag = '0;
        dcache_fill_ready = 1'b1;
        chk("t1_fill_wr", 64'(mshr2Dcache_wr), 64'd1);
        tick();
        dcache_fill_ready = 1'b0;
        chk("t1_freed", 64'(mshr2Dcache_wr), 64'd0);

        // transaction tag retry
        set_miss(32'h1000, 1'b0, BYTE, 32'h0);
        tick(); clr_miss();
        for (int k = 0; k < 3; k++) begin
            mem2proc_transaction_tag = (k == 2) ? 4'd5 : 4'd0;
            if (k == 2) q_bus.push_back(32'h1000);
            chk("t2_cmd_hold", 64'(proc2mem_command), 64'(BUS_LOAD));
            chk("t2_addr_hold", 64'(proc2mem_addr), 64'h1000);
            tick();
        end
        mem2proc_transaction_tag = '0;
        chk("t2_issued", 64'(proc2mem_command), 64'(BUS_NONE));
        mem2proc_data_tag = 4'd3;
        mem2proc_data = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        mem2proc_data_tag = '0;
        chk("t2_wrong_tag_ignored", 64'(mshr2Dcache_wr), 64'd0);
        respond(4'd5, 32'h1000, 64'h5555_0000_5555_0000, 1'b0, BYTE, 32'h0);
        tick();
        mem2proc_data_tag = '0;
        dcache_fill_ready = 1'b1;
        tick();
        dcache_fill_ready = 1'b0;

        // fill all entries, out-of-order responses, stalled fill
        for (int k = 0; k < 4; k++) begin
            set_miss(32'h100 * (k + 1), 1'b0, BYTE, 32'h0);
            tick();
        end
        set_miss(32'h500, 1'b0, BYTE, 32'h0);
        chk("t3_full", 64'(miss_ready), 64'd0);
        tick(); clr_miss();
        chk("t3_fifth_dropped", 64'(miss_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            mem2proc_transaction_tag = 4'(k + 1);
            q_bus.push_back(32'h100 * (k + 1));
            tick();
        end
        mem2proc_transaction_tag = '0;
        respond(4'd4, 32'h400, {32'd4, 32'h400}, 1'b0, BYTE, 32'h0);
        tick();
        mem2proc_data_tag = '0;
        for (int k = 0; k < 3; k++) begin
            chk("t3_stall_wr", 64'(mshr2Dcache_wr), 64'd1);
            chk("t3_stall_addr", 64'(mshr2Dcache_addr), 64'h400);
            chk("t3_stall_blk", mshr2Dcache_mem_block, {32'd4, 32'h400});
            chk("t3_stall_full", 64'(miss_ready), 64'd0);
            tick();
        end
        dcache_fill_ready = 1'b1;
        respond(4'd2, 32'h200, {32'd2, 32'h200}, 1'b0, BYTE, 32'h0);
        chk("t3_ready_before_grant", 64'(miss_ready), 64'd0);
        tick();
        mem2proc_data_tag = '0;
        chk("t3_ready_after_grant", 64'(miss_ready), 64'd1);
        tick();
        respond(4'd3, 32'h300, {32'd3, 32'h300}, 1'b0, BYTE, 32'h0);
        tick();
        respond(4'd1, 32'h100, {32'd1, 32'h100}, 1'b0, BYTE, 32'h0);
        tick();
        mem2proc_data_tag = '0;
        tick();
        dcache_fill_ready = 1'b0;
        chk("t3_drained", 64'(q_fill.size()), 64'd0);

        // store miss payload
        set_miss(32'h2006, 1'b1, HALF, 32'hBEEF);
        q_bus.push_back(32'h2000);
        tick(); clr_miss();
        mem2proc_transaction_tag = 4'd6;
        tick();
        mem2proc_transaction_tag = '0;
        respond(4'd6, 32'h2006, 64'h0123_4567_89AB_CDEF, 1'b1, HALF, 32'hBEEF);
        tick();
        mem2proc_data_tag = '0;
        dcache_fill_ready = 1'b1;
        chk("t4_is_store", 64'(mshr2Dcache_is_store), 64'd1);
        chk("t4_st_size", 64'(mshr2Dcache_st_size), 64'(HALF));
        chk("t4_st_data", 64'(mshr2Dcache_st_data), 64'hBEEF);
        chk("t4_addr", 64'(mshr2Dcache_addr), 64'h2006);
        tick();
        dcache_fill_ready = 1'b0;

        // same-block second load while first is in flight
        set_miss(32'h3000, 1'b0, BYTE, 32'h0);
        q_bus.push_back(32'h3000);
        tick(); clr_miss();
        mem2proc_transaction_tag = 4'd8;
        tick();
        mem2proc_transaction_tag = '0;
        set_miss(32'h3004, 1'b0, BYTE, 32'h0);
`ifdef DCACHE_MSHR_MERGE_EN
        chk("t5_merged", 64'(miss_merged), 64'd1);
        tick(); clr_miss();
        chk("t5_single_fetch", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("t5_merge_pulse", 64'(miss_merged), 64'd0);
`else
        q_bus.push_back(32'h3000);
        tick(); clr_miss();
        mem2proc_transaction_tag = 4'd9;
        chk("t5_second_fetch", 64'(proc2mem_command), 64'(BUS_LOAD));
        tick();
        mem2proc_transaction_tag = '0;
`endif
        respond(4'd8, 32'h3000, 64'h3333_3333_0000_0008, 1'b0, BYTE, 32'h0);
        tick();
        dcache_fill_ready = 1'b1;
        mem2proc_data_tag = '0;
`ifndef DCACHE_MSHR_MERGE_EN
        respond(4'd9, 32'h3004, 64'h3333_3333_0000_0009, 1'b0, BYTE, 32'h0);
`endif
        tick();
        mem2proc_data_tag = '0;
        tick();
        dcache_fill_ready = 1'b0;

        // reset with a request outstanding; the late response must be dropped
        set_miss(32'h5000, 1'b0, BYTE, 32'h0);
        q_bus.push_back(32'h5000);
        tick(); clr_miss();
        mem2proc_transaction_tag = 4'd10;
        tick();
        mem2proc_transaction_tag = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dcache_fill_ready = 1'b1;
        mem2proc_data_tag = 4'd10;
        mem2proc_data = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        mem2proc_data_tag = '0;
        chk("t6_late_resp_ignored", 64'(mshr2Dcache_wr), 64'd0);
        chk("t6_cmd_idle", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("t6_ready", 64'(miss_ready), 64'd1);
        tick();
        chk("t6_still_idle", 64'(mshr2Dcache_wr), 64'd0);
        dcache_fill_ready = 1'b0;

        tick(); tick();
        chk("end_bus_queue_empty", 64'(q_bus.size()), 64'd0);
        chk("end_fill_queue_empty", 64'(q_fill.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
